// File: rtl/dl_piso_tx.sv
// ============================================================================
// dl_piso_tx -- parallel-in, serial-out transmitter
// ----------------------------------------------------------------------------
// Accepts one WIDTH-bit word per valid/ready handshake and emits it one bit
// per clock on a registered single-bit output.  Framing is marked by ser_vld
// (bit present) and ser_last (final bit of the frame).  This is the transmit
// end of the single-bit serial link whose receive end is a chain of dl_dff
// stages feeding a deserializer.
//
// Frames are gapless: a word offered during the last-bit cycle of the
// current frame is accepted there and its first bit follows immediately.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   LSB_FIRST  1: bit 0 leaves first; 0: bit WIDTH-1 leaves first
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_vld     in_data holds a word to send
//   in_rdy     a word can be accepted this cycle (low while rst_n is low)
//   in_data    parallel word, sampled only on accept
//   ser_out    serial data bit (registered, 0 when ser_vld is 0)
//   ser_vld    ser_out carries a frame bit (registered)
//   ser_last   ser_out is the final bit of the frame (registered)
//   busy       frame in progress, identical to ser_vld
// ============================================================================
module dl_piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_vld,
    output logic             ser_last,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;   // bits still to be sent
    logic [CNT_W-1:0]   cnt_q,   cnt_d;     // index of the bit on ser_out
    logic               ser_out_q,  ser_out_d;
    logic               ser_vld_q,  ser_vld_d;
    logic               ser_last_q, ser_last_d;

    logic               at_last;
    logic               accept;

    // The last-bit cycle is the only SHIFT cycle that can take a new word.
    assign at_last = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // in_rdy depends only on flops and rst_n, never on in_vld.
    assign in_rdy  = rst_n && ((state_q == IDLE) || at_last);
    assign accept  = in_vld && in_rdy;

    // ------------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples the pre-edge value of its inputs, regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (at_last && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Process 3: output / datapath next values
    // ------------------------------------------------------------------------
    // ser_out is registered, so the bit for the next cycle is chosen here.
    // On accept the first bit is taken straight from in_data and the shift
    // register keeps the remaining bits already shifted by one; afterwards
    // each step pops the next bit from the leading end of the shift register.
    always_comb begin
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        ser_out_d  = 1'b0;
        ser_vld_d  = 1'b0;
        ser_last_d = 1'b0;

        if (accept) begin
            cnt_d     = '0;
            ser_vld_d = 1'b1;
            if (LSB_FIRST) begin
                ser_out_d = in_data[0];
                shreg_d   = in_data >> 1;
            end else begin
                ser_out_d = in_data[WIDTH-1];
                shreg_d   = in_data << 1;
            end
        end else if ((state_q == SHIFT) && !at_last) begin
            cnt_d      = cnt_q + 1'b1;
            ser_vld_d  = 1'b1;
            ser_last_d = (cnt_d == CNT_LAST);
            if (LSB_FIRST) begin
                ser_out_d = shreg_q[0];
                shreg_d   = shreg_q >> 1;
            end else begin
                ser_out_d = shreg_q[WIDTH-1];
                shreg_d   = shreg_q << 1;
            end
        end else if (at_last) begin
            // Frame ends with no successor: drop back to a clean idle link.
            cnt_d   = '0;
            shreg_d = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------------
    // NOTE: the shift register is cleared on reset too; it is a handful of
    // flops, and a known value keeps a mid-frame abort fully deterministic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            ser_out_q  <= 1'b0;
            ser_vld_q  <= 1'b0;
            ser_last_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            ser_out_q  <= ser_out_d;
            ser_vld_q  <= ser_vld_d;
            ser_last_q <= ser_last_d;
        end
    end

    assign ser_out  = ser_out_q;
    assign ser_vld  = ser_vld_q;
    assign ser_last = ser_last_q;
    assign busy     = ser_vld_q;

endmodule
